// File: rtl/spike_encoder.sv
`default_nettype none
// =====================================================================
// Module : spike_encoder
// Rate-codes each row of a 24-lane pixel SPBRAM image into a spike
// bundle by comparing shifted intensities against per-lane Galois LFSRs.
// Rev    : 1.0
// =====================================================================
module spike_encoder #(
    parameter int unsigned SEED   = 1000,
    parameter int unsigned N_ROWS = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_run,
    input  logic         i_init,
    input  logic [2:0]   i_rate_shift,
    output logic [4:0]   addr,
    output logic         ce,
    input  logic [191:0] q,
    output logic [23:0]  o_spike_bundle,
    output logic         o_valid,
    output logic         o_done,
    output logic         o_busy,
    output logic [9:0]   o_spike_cnt
);

    localparam int unsigned c_lanes    = 24;
    localparam logic [4:0]  c_last_row = 5'(N_ROWS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [4:0]  r_row;
    logic        r_ce_d;
    logic        r_valid;
    logic [23:0] r_bundle;
    logic [9:0]  r_cnt;
    logic [2:0]  r_shift;

    logic        w_start;
    logic [23:0] w_bundle;
    logic [4:0]  w_pop;

    assign w_start = (r_state == S_IDLE) && i_run && !i_init;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_run) w_next = S_READ;
            S_READ:  if (r_row == c_last_row) w_next = S_DRAIN;
            // The final bundle is on the output once the read pipe is empty.
            S_DRAIN: if (r_valid && !r_ce_d) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (i_init) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row    <= '0;
            r_ce_d   <= 1'b0;
            r_valid  <= 1'b0;
            r_bundle <= '0;
            r_cnt    <= '0;
            r_shift  <= '0;
        end else if (i_init) begin
            r_row    <= '0;
            r_ce_d   <= 1'b0;
            r_valid  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_ce_d  <= (r_state == S_READ);
            r_valid <= r_ce_d;
            if (w_start) begin
                r_row   <= '0;
                r_cnt   <= '0;
                r_shift <= i_rate_shift;
            end else if (r_state == S_READ) begin
                r_row <= (r_row == c_last_row) ? 5'd0 : r_row + 5'd1;
            end
            if (r_ce_d) begin
                r_bundle <= w_bundle;
                r_cnt    <= r_cnt + {5'd0, w_pop};
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int l = 0; l < c_lanes; l++) begin
            w_pop = w_pop + {4'd0, w_bundle[l]};
        end
    end

    for (genvar l = 0; l < 24; l++) begin : g_lane
        localparam int unsigned c_raw  = (SEED + 97 * l) % 65536;
        localparam logic [15:0] c_seed = (c_raw == 0) ? 16'd1 : 16'(c_raw);

        logic [15:0] r_lfsr;
        logic [7:0]  w_pix;

        assign w_pix       = q[l*8 +: 8] >> r_shift;
        assign w_bundle[l] = (w_pix > r_lfsr[7:0]);

        // Advance only on cycles where a pixel row is being compared.
        always_ff @(posedge clk) begin
            if (reset || i_init) begin
                r_lfsr <= c_seed;
            end else if (r_ce_d) begin
                r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
            end
        end
    end

    assign addr           = r_row;
    assign ce             = (r_state == S_READ);
    assign o_spike_bundle = r_bundle;
    assign o_valid        = r_valid;
    assign o_done         = (r_state == S_DONE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_spike_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spike_encoder.sv
`default_nettype none
// =====================================================================
// Module : tb_spike_encoder
// Scoreboard bench: a lane-level rate-coding model predicts every bundle.
// Rev    : 1.0
// =====================================================================
module tb_spike_encoder;

    localparam int N    = 24;
    localparam int SEED = 1000;

    typedef struct { logic [23:0] b; int cyc; } exp_t;
    typedef struct { int cyc; int cnt; } done_t;
    typedef logic [23:0] seq_t[$];

    logic         clk = 1'b0;
    logic         reset, i_run, i_init;
    logic [2:0]   i_rate_shift;
    logic [4:0]   addr;
    logic         ce;
    logic [191:0] q = '0;
    logic [23:0]  o_spike_bundle;
    logic         o_valid, o_done, o_busy;
    logic [9:0]   o_spike_cnt;

    spike_encoder #(.SEED(SEED), .N_ROWS(N)) dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_init(i_init),
        .i_rate_shift(i_rate_shift), .addr(addr), .ce(ce), .q(q),
        .o_spike_bundle(o_spike_bundle), .o_valid(o_valid), .o_done(o_done),
        .o_busy(o_busy), .o_spike_cnt(o_spike_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] img [N][24];
    always @(posedge clk) begin
        if (ce && addr < 5'd24)
            for (int l = 0; l < 24; l++) q[l*8 +: 8] <= img[addr][l];
    end

    int n_vec = 0, n_err = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr [24];
    exp_t  exp_q[$];
    done_t done_q[$];
    seq_t  cap;

    task automatic m_reseed();
        for (int l = 0; l < 24; l++) begin
            int s = (SEED + 97 * l) % 65536;
            m_lfsr[l] = (s == 0) ? 16'd1 : 16'(s);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic m_run(input int shift, input int t0);
        int total = 0;
        for (int k = 0; k < N; k++) begin
            logic [23:0] b = '0;
            for (int l = 0; l < 24; l++) begin
                if ((int'(img[k][l]) >> shift) > int'(m_lfsr[l][7:0])) b[l] = 1'b1;
                m_lfsr[l] = m_step(m_lfsr[l]);
            end
            exp_q.push_back('{b: b, cyc: t0 + k + 2});
            total += $countones(b);
        end
        done_q.push_back('{cyc: t0 + N + 2, cnt: total});
    endtask

    // ---------------- monitor ----------------
    bit mon_en = 1'b0;
    int busy_from = 1, busy_to = 0, ce_from = 1, ce_to = 0;
    exp_t  mon_e;
    done_t mon_d;

    always @(negedge clk) begin
        if (mon_en) begin
            if (o_valid) begin
                cap.push_back(o_spike_bundle);
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("bundle", 32'(o_spike_bundle), 32'(mon_e.b));
                    chk("valid_cycle", cyc, mon_e.cyc);
                end
            end
            if (o_done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_cycle", cyc, mon_d.cyc);
                    chk("done_spike_cnt", 32'(o_spike_cnt), mon_d.cnt);
                    chk("done_valid_low", 32'(o_valid), 32'd0);
                end
            end
            chk("busy", 32'(o_busy), 32'(cyc >= busy_from && cyc <= busy_to));
            chk("ce", 32'(ce), 32'(cyc >= ce_from && cyc <= ce_to));
            if (ce) chk("addr", 32'(addr), cyc - ce_from);
        end
    end

    // ---------------- driver ----------------
    int t0;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_img(input int mode);
        for (int k = 0; k < N; k++)
            for (int l = 0; l < 24; l++)
                img[k][l] = (mode == 0) ? 8'd0 : (mode == 1) ? 8'd255 : 8'($urandom_range(0, 255));
    endtask

    task automatic start_run(input int shift);
        next();
        i_run = 1'b1;
        i_rate_shift = 3'(shift);
        t0 = cyc + 1;
        m_run(shift, t0);
        busy_from = t0; busy_to = t0 + N + 2;
        ce_from = t0;   ce_to = t0 + N - 1;
        cap.delete();
        next();
        i_run = 1'b0;
    endtask

    task automatic wait_run();
        repeat (N + 6) next();
        chk("run_complete", exp_q.size() + done_q.size(), 0);
    endtask

    task automatic abort(input bit use_reset);
        if (use_reset) reset = 1'b1; else i_init = 1'b1;
        if (cyc < busy_to) busy_to = cyc;
        if (cyc < ce_to) ce_to = cyc;
        next();
        reset = 1'b0;
        i_init = 1'b0;
        exp_q.delete();
        done_q.delete();
        m_reseed();
    endtask

    function automatic int n_diff(input seq_t a, input seq_t b);
        int d = 0;
        if (a.size() != b.size()) return 1000;
        foreach (a[i]) if (a[i] !== b[i]) d++;
        return d;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(addr), 0);
        chk({tag, "_ce"}, 32'(ce), 0);
        chk({tag, "_bundle"}, 32'(o_spike_bundle), 0);
        chk({tag, "_valid"}, 32'(o_valid), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_cnt"}, 32'(o_spike_cnt), 0);
    endtask

    seq_t s_ref, s1, s2, s3;

    initial begin
        reset = 1'b1; i_run = 1'b0; i_init = 1'b0; i_rate_shift = '0;
        fill_img(0);
        repeat (3) next();
        reset = 1'b0;
        m_reseed();
        chk_all_zero("reset");
        mon_en = 1'b1;

        // Full-intensity image straight after reset, kept as the reference sequence.
        fill_img(1); start_run(0); wait_run(); s_ref = cap;
        fill_img(0); start_run(0); wait_run();
        fill_img(1); start_run(7); wait_run();
        for (int r = 0; r < 3; r++) begin
            fill_img(2); start_run(int'($urandom_range(0, 7))); wait_run();
        end

        // Reseeding makes a run repeatable; without it the LFSRs have moved on.
        fill_img(2);
        next(); abort(0);
        start_run(2); wait_run(); s1 = cap;
        next(); abort(0);
        start_run(2); wait_run(); s2 = cap;
        chk("init_repeat_same", n_diff(s1, s2), 0);
        start_run(2); wait_run(); s3 = cap;
        chk("noinit_repeat_differs", 32'(n_diff(s2, s3) != 0), 1);

        // A run pulse while busy must be ignored.
        fill_img(2); start_run(1);
        repeat (5) next();
        i_run = 1'b1;
        next();
        i_run = 1'b0;
        wait_run();

        // Abort with init at t0+10.
        fill_img(2); start_run(3);
        repeat (10) next();
        abort(0);
        chk("init_abort_valid", 32'(o_valid), 0);
        chk("init_abort_busy", 32'(o_busy), 0);
        chk("init_abort_ce", 32'(ce), 0);
        chk("init_abort_cnt", 32'(o_spike_cnt), 0);
        repeat (N + 4) next();

        // init wins over a simultaneous run.
        next();
        i_init = 1'b1; i_run = 1'b1;
        next();
        i_init = 1'b0; i_run = 1'b0;
        m_reseed();
        chk("init_beats_run_busy", 32'(o_busy), 0);
        repeat (4) next();

        // Reset at t0+12, then the post-reset sequence must reappear.
        fill_img(1); start_run(0);
        repeat (12) next();
        abort(1);
        chk_all_zero("midreset");
        repeat (3) next();
        start_run(0); wait_run();
        chk("post_reset_repeat", n_diff(cap, s_ref), 0);

        repeat (5) next();
        chk("pending_bundles", exp_q.size(), 0);
        chk("pending_done", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 The block SHALL have parameter SEED, default 1000, base seed for the lane LFSRs.
REQ-002 The block SHALL have parameter N_ROWS, default 24, bundles emitted per timestep.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_run, input, 1 bit: one-cycle pulse that starts one timestep.
REQ-006 The block SHALL have port i_init, input, 1 bit: one-cycle pulse that reseeds the LFSRs and aborts any timestep.
REQ-007 The block SHALL have port i_rate_shift, input, 3 bits: right shift applied to each pixel intensity.
REQ-008 The block SHALL have port addr, output, 5 bits: pixel SPBRAM row address.
REQ-009 The block SHALL have port ce, output, 1 bit: pixel SPBRAM chip enable. The pixel SPBRAM is read-only, so the block has no write enable.
REQ-010 The block SHALL have port q, input, 192 bits: pixel SPBRAM data, 24 lanes of 8 bits; lane l is q[l*8 +: 8].
REQ-011 The block SHALL have port o_spike_bundle, output, 24 bits: one spike bit per lane; it feeds the synapse spike-bundle input.
REQ-012 The block SHALL have port o_valid, output, 1 bit: qualifies o_spike_bundle.
REQ-013 The block SHALL have port o_done, output, 1 bit: one-cycle pulse marking timestep end.
REQ-014 The block SHALL have port o_busy, output, 1 bit: high while a timestep is in progress.
REQ-015 The block SHALL have port o_spike_cnt, output, 10 bits: total spikes emitted in the current or last timestep.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, READ, DRAIN and DONE.
REQ-017 IDLE SHALL go to READ on i_run. READ SHALL go to DRAIN after issuing row N_ROWS-1. DRAIN SHALL go to DONE after the last o_valid. DONE SHALL go to IDLE after one cycle.
REQ-018 Let t0 be the cycle after i_run. In READ the block SHALL drive addr=k and ce=1 in cycle t0+k, for k = 0..N_ROWS-1; ce SHALL be 0 in every other cycle.
REQ-019 The pixel SPBRAM SHALL have 1-cycle read latency. q for row k SHALL be sampled in cycle t0+k+1.
REQ-020 The bundle for row k SHALL be registered, with o_valid=1 in cycle t0+k+2. This gives N_ROWS consecutive valid cycles with no gaps.
REQ-021 Spike bit l SHALL be 1 iff (pixel_l >> i_rate_shift) > lfsr_l[7:0]. The comparison is unsigned, 8 bits.
REQ-022 i_rate_shift SHALL be sampled on i_run and held for the whole timestep.
REQ-023 The block SHALL hold 24 independent 16-bit Galois LFSRs with polynomial x^16+x^14+x^13+x^11+1 (mask 0xB400).
REQ-024 Each LFSR SHALL advance exactly once per q sample, after the compare, and at no other time.
REQ-025 The seed of lane l SHALL be (SEED + 97*l) mod 65536; a seed that computes to 0 SHALL be replaced by 1.
REQ-026 o_spike_bundle SHALL hold its last value when o_valid=0; it is not zeroed.
REQ-027 o_spike_cnt SHALL clear to 0 at t0 and accumulate the popcount of every valid bundle.
REQ-028 o_spike_cnt SHALL be final in the o_done cycle and hold until the next i_run. Its maximum is 576, so it cannot overflow.
REQ-029 o_done SHALL be 1 for exactly one cycle, at t0+N_ROWS+2, with o_valid=0 in that cycle.
REQ-030 o_busy SHALL be 1 from t0 through the o_done cycle inclusive.
REQ-031 i_run SHALL be ignored while o_busy=1.
REQ-032 i_init SHALL have priority over i_run in the same cycle: no timestep starts.
REQ-033 i_init in any state SHALL reseed all LFSRs, clear o_spike_cnt, deassert o_valid, o_busy and ce, and return the FSM to IDLE.
REQ-034 An aborted timestep SHALL produce no o_done.
REQ-035 Pixel value 0 SHALL never spike. Pixel 255 with shift 0 SHALL spike unless lfsr[7:0]=255.

Reset
REQ-036 On reset the FSM SHALL go to IDLE and the LFSRs SHALL load their seeds.
REQ-037 On reset addr, ce, o_spike_bundle, o_valid, o_done, o_busy and o_spike_cnt SHALL all be 0.
REQ-038 Reset mid-timestep SHALL take effect on the next edge and produce no further o_valid or o_done.

Verification
REQ-039 Scenario: all pixels 0, i_run -> 24 valid cycles starting at t0+2, every bundle 0, o_done at t0+26, o_spike_cnt=0.
REQ-040 Scenario: all pixels 255, shift 0, SEED=1000 -> each bit matches a reference model of the 24 lanes bit-exactly; o_spike_cnt equals the model total.
REQ-041 Scenario: identical image run twice with i_init between runs -> identical bundle sequences. Run twice without i_init -> sequences differ.
REQ-042 Scenario: shift 7 with all pixels 255 -> spike only where lfsr[7:0]=0; verify against the model.
REQ-043 Scenario: i_run pulse at t0+5 while busy -> ignored, exactly 24 valids. i_init at t0+10 -> o_valid low from t0+11, no o_done.
REQ-044 Scenario: reset asserted at t0+12 -> all outputs 0 next cycle; a following i_run reproduces the post-reset sequence exactly.
